id_run_stats: RTL

ID_RUN_STATS -- requirements
Module: id_run_stats

---
 rtl/id_run_stats_if.sv | 25 ++
 rtl/id_run_stats.sv | 127 ++++++++++++
 2 files changed

// File: rtl/id_run_stats_if.sv
// Bus bundle for id_run_stats: recognizer handshake and clear inward,
// run statistics outward.
interface id_run_stats_if #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 4
);
    logic             valid;
    logic             match;
    logic             clear;
    logic [CNT_W-1:0] id_count;
    logic [LEN_W-1:0] cur_len;
    logic [LEN_W-1:0] max_len;
    logic             done;
    logic             ovf;

    modport master (
        output valid, match, clear,
        input  id_count, cur_len, max_len, done, ovf
    );

    modport slave (
        input  valid, match, clear,
        output id_count, cur_len, max_len, done, ovf
    );
endinterface

// File: rtl/id_run_stats.sv
// Run-length statistics over a letters-then-digits recognizer's match flag:
// counts completed runs, tracks current and longest run, flags count overflow.
module id_run_stats #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    id_run_stats_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [LEN_W-1:0] cur_len_r;
    logic [LEN_W-1:0] cur_len_nxt_s;
    logic [LEN_W-1:0] max_len_r;
    logic [LEN_W-1:0] max_len_nxt_s;
    logic [CNT_W-1:0] id_count_r;
    logic [CNT_W-1:0] id_count_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             run_end_s;

    // State and output registers; clear behaves exactly like reset and beats a run end.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            state_r    <= IDLE;
            cur_len_r  <= LEN_ZERO;
            max_len_r  <= LEN_ZERO;
            id_count_r <= CNT_ZERO;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cur_len_r  <= cur_len_nxt_s;
            max_len_r  <= max_len_nxt_s;
            id_count_r <= id_count_nxt_s;
            done_r     <= done_nxt_s;
            ovf_r      <= ovf_nxt_s;
        end
    end

    // Next-state logic: only consumed characters move the FSM.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.valid) begin
            case (state_r)
                IDLE: begin
                    if (bus.match) state_nxt_s = RUN;
                    else           state_nxt_s = IDLE;
                end
                RUN: begin
                    if (bus.match) state_nxt_s = RUN;
                    else           state_nxt_s = IDLE;
                end
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Next values of the statistics registers.
    always_comb begin
        run_end_s      = bus.valid && (state_r == RUN) && !bus.match;
        cur_len_nxt_s  = cur_len_r;
        max_len_nxt_s  = max_len_r;
        id_count_nxt_s = id_count_r;
        done_nxt_s     = run_end_s;
        ovf_nxt_s      = ovf_r;

        if (bus.valid) begin
            case (state_r)
                IDLE: begin
                    if (bus.match) cur_len_nxt_s = LEN_ONE;
                    else           cur_len_nxt_s = LEN_ZERO;
                end
                RUN: begin
                    if (!bus.match)              cur_len_nxt_s = LEN_ZERO;
                    else if (cur_len_r == LEN_MAX) cur_len_nxt_s = LEN_MAX;
                    else                         cur_len_nxt_s = cur_len_r + LEN_ONE;
                end
                default: cur_len_nxt_s = LEN_ZERO;
            endcase
        end else begin
            cur_len_nxt_s = cur_len_r;
        end

        // A finished run is scored with the length it had before this edge.
        if (run_end_s) begin
            if (id_count_r == CNT_MAX) begin
                id_count_nxt_s = CNT_MAX;
                ovf_nxt_s      = 1'b1;
            end else begin
                id_count_nxt_s = id_count_r + CNT_ONE;
                ovf_nxt_s      = ovf_r;
            end
            if (cur_len_r > max_len_r) max_len_nxt_s = cur_len_r;
            else                       max_len_nxt_s = max_len_r;
        end else begin
            id_count_nxt_s = id_count_r;
            max_len_nxt_s  = max_len_r;
            ovf_nxt_s      = ovf_r;
        end
    end

    assign bus.cur_len  = cur_len_r;
    assign bus.max_len  = max_len_r;
    assign bus.id_count = id_count_r;
    assign bus.done     = done_r;
    assign bus.ovf      = ovf_r;

endmodule
